mode_sequencer: RTL

MODE_SEQUENCER -- requirements
Module: mode_sequencer

---
 rtl/mode_seq_pkg.sv | 15 +
 rtl/mode_sequencer_if.sv | 12 +
 rtl/mode_sequencer_key_debounce.sv | 130 +++++++++++++
 rtl/mode_sequencer.sv | 85 ++++++++
 4 files changed

// File: rtl/mode_seq_pkg.sv
// Shared definitions for the mode sequencer: key FSM encoding, mode width, parameter defaults.
package mode_seq_pkg;

  localparam int unsigned MODE_W              = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 25000000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

endpackage

// File: rtl/mode_sequencer_if.sv
// Pushbutton/mode bundle of the mode sequencer; master drives keys, slave returns mode state.
interface mode_sequencer_if;
  import mode_seq_pkg::*;

  logic [1:0]        key;
  logic [MODE_W-1:0] mode;
  logic              mode_chg;
  logic [1:0]        key_stable;

  modport master (output key, input mode, mode_chg, key_stable);
  modport slave  (input key, output mode, mode_chg, key_stable);
endinterface

// File: rtl/mode_sequencer_key_debounce.sv
// Per-key synchronizer + debounce FSM raising a registered one-cycle press event.
// Optional auto-repeat while held is compiled in with MODE_SEQ_AUTOREPEAT_EN.
module key_debounce
  import mode_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef MODE_SEQ_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
`ifdef MODE_SEQ_AUTOREPEAT_EN
  input  logic other_held,
  output logic held,
`endif
  output logic stable,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1, sync2, sample;
  key_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          press_nx, press_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign sample  = ~sync2;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    press_nx = 1'b0;
    unique case (state)
      RELEASED: begin
        cnt_nx = '0;
        if (sample) begin
          state_nx = PRESS_PEND;
          cnt_nx   = CW'(1);
        end
      end
      PRESS_PEND: begin
        if (!sample) begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end else if (cnt_inc >= CNT_MAX) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      PRESSED: begin
        cnt_nx = '0;
        if (!sample) begin
          state_nx = RELEASE_PEND;
          cnt_nx   = CW'(1);
        end
      end
      RELEASE_PEND: begin
        if (sample) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt_inc >= CNT_MAX) begin
          state_nx = RELEASED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
    endcase
  end

`ifdef MODE_SEQ_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES);

  logic [RW-1:0] rep, rep_nx;
  logic          rep_fire;

  // Counts only while staying in PRESSED; any exit, re-entry or dual hold restarts it.
  always_comb begin
    rep_nx   = '0;
    rep_fire = 1'b0;
    if (state == PRESSED && state_nx == PRESSED && !other_held) begin
      if (rep == REP_MAX - RW'(1)) rep_fire = 1'b1;
      else                         rep_nx   = rep + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep <= '0;
    else     rep <= rep_nx;
  end

  assign held      = (state == PRESSED);
  assign press_evt = press_nx | rep_fire;
`else
  assign press_evt = press_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      press <= press_evt;
    end
  end

  assign stable = (state == PRESSED) || (state == RELEASE_PEND);

endmodule

// File: rtl/mode_sequencer.sv
// Two-key mode selector: KEY[0] steps MODE up, KEY[1] down, both together clear it.
// Auto-repeat of held keys is enabled by defining MODE_SEQ_AUTOREPEAT_EN.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RST,
  input  logic [1:0]        KEY,
  output logic [MODE_W-1:0] MODE,
  output logic              MODE_CHG,
  output logic [1:0]        KEY_STABLE
);

  // RELEASED loads the counter with 1, so acceptance needs at least two samples.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("mode_sequencer: DEBOUNCE_CYCLES must be >= 2 and REPEAT_CYCLES >= 1");
  end

  logic [1:0] press;
`ifdef MODE_SEQ_AUTOREPEAT_EN
  logic [1:0] held;
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MODE_SEQ_AUTOREPEAT_EN
    , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_key0 (
    .clk        (MAX10_CLK1_50),
    .rst        (RST),
    .key_n      (KEY[0]),
`ifdef MODE_SEQ_AUTOREPEAT_EN
    .other_held (held[1]),
    .held       (held[0]),
`endif
    .stable     (KEY_STABLE[0]),
    .press      (press[0])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef MODE_SEQ_AUTOREPEAT_EN
    , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
  ) u_key1 (
    .clk        (MAX10_CLK1_50),
    .rst        (RST),
    .key_n      (KEY[1]),
`ifdef MODE_SEQ_AUTOREPEAT_EN
    .other_held (held[0]),
    .held       (held[1]),
`endif
    .stable     (KEY_STABLE[1]),
    .press      (press[1])
  );

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      MODE     <= '0;
      MODE_CHG <= 1'b0;
    end else begin
      MODE_CHG <= 1'b0;
      unique case (press)
        2'b01: begin
          MODE     <= MODE + MODE_W'(1);
          MODE_CHG <= 1'b1;
        end
        2'b10: begin
          MODE     <= MODE - MODE_W'(1);
          MODE_CHG <= 1'b1;
        end
        2'b11: begin
          MODE     <= '0;
          MODE_CHG <= (MODE != '0);
        end
        default: ;
      endcase
    end
  end

endmodule
